// File: rtl/monolith_axis_pkg.sv
// Shared types and helpers for the Monolith AXI-Stream chunk FIFO.
package monolith_axis_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } chunk_wr_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/monolith_chunk_ram.sv
// Word-addressed write port, chunk-wide registered read port; contents are not reset.
module monolith_chunk_ram
    import monolith_axis_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int COUNT = 2,
    parameter int W     = 32
) (
    input  logic                                 clk,
    input  logic                                 wr_en,
    input  logic [clog2_min1(SIZE*COUNT)-1:0]    wr_addr,
    input  logic [W-1:0]                         wr_data,
    input  logic                                 rd_en,
    input  logic [clog2_min1(COUNT)-1:0]         rd_addr,
    output logic [W-1:0]                         rd_data [0:SIZE-1]
);
    localparam int DEPTH = SIZE * COUNT;
    localparam int SA    = clog2_min1(SIZE);

    logic [W-1:0] mem_q     [0:DEPTH-1];
    logic [W-1:0] rd_data_q [0:SIZE-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            for (int i = 0; i < SIZE; i++) begin
                rd_data_q[i] <= mem_q[{rd_addr, SA'(i)}];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/monolith_axis_chunk_fifo_slave.sv
// AXI4-Stream sink that packs words into fixed-size chunks (zero-padded on TLAST)
// and hands one whole chunk at a time to the Monolith hash core.
module monolith_axis_chunk_fifo_slave
    import monolith_axis_pkg::*;
#(
    parameter int FIFO_CHUNK_SIZE      = 16,
    parameter int FIFO_CHUNK_COUNT     = 2,
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_chunk_data [0:FIFO_CHUNK_SIZE-1],
    output logic                              m_chunk_valid,
    input  logic                              m_chunk_ready,
    output logic                              m_chunk_last,
    output logic [$clog2(FIFO_CHUNK_SIZE):0]  m_chunk_words,
    output logic [$clog2(FIFO_CHUNK_SIZE*FIFO_CHUNK_COUNT):0] fifo_level,
    output logic [$clog2(FIFO_CHUNK_COUNT):0] chunks_avail
);
    localparam int SIZE  = FIFO_CHUNK_SIZE;
    localparam int COUNT = FIFO_CHUNK_COUNT;
    localparam int W     = C_S_AXIS_TDATA_WIDTH;
    localparam int DEPTH = SIZE * COUNT;
    localparam int WA    = $clog2(DEPTH);
    localparam int CA    = $clog2(COUNT);
    localparam int SA    = clog2_min1(SIZE);
    localparam int NW    = $clog2(SIZE) + 1;

    typedef struct packed {
        logic          last;
        logic [NW-1:0] words;
    } chunk_meta_t;

    chunk_wr_state_t state_q, state_d;
    logic [WA-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CA-1:0]   rd_ptr_q, rd_ptr_d;
    logic [WA:0]     level_q, level_d;
    logic [CA:0]     chunks_q, chunks_d;
    logic [NW-1:0]   pad_words_q, pad_words_d;
    logic            tready_q, tready_d;
    logic            valid_q, valid_d;
    chunk_meta_t     out_meta_q, out_meta_d;
    chunk_meta_t     meta_q [0:COUNT-1];
    chunk_meta_t     meta_d [0:COUNT-1];

    logic            hs, wr_en, commit, load;
    logic [W-1:0]    wr_data;
    logic [SA-1:0]   word_idx;
    logic [CA-1:0]   wr_slot;
    logic [W-1:0]    ram_rd [0:SIZE-1];
    logic            strb_unused;

    assign strb_unused = ^S_AXIS_TSTRB;
    // Storage is chunk-aligned, so the pointer splits into slot and word index.
    assign word_idx = wr_ptr_q[SA-1:0];
    assign wr_slot  = wr_ptr_q[WA-1:SA];

    always_comb begin
        hs      = (state_q == FILL) && S_AXIS_TVALID && tready_q;
        wr_en   = hs || ((state_q == PAD) && (level_q != (WA+1)'(DEPTH)));
        wr_data = (state_q == PAD) ? '0 : S_AXIS_TDATA;
        commit  = wr_en && (word_idx == SA'(SIZE - 1));
        load    = (chunks_q != '0) && (!valid_q || m_chunk_ready);

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pad_words_d = pad_words_q;
        meta_d      = meta_q;
        rd_ptr_d    = rd_ptr_q;
        valid_d     = valid_q;
        out_meta_d  = out_meta_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            FILL: if (hs && S_AXIS_TLAST && !commit) begin
                state_d     = PAD;
                pad_words_d = NW'(word_idx) + 1'b1;
            end
            PAD: if (commit) begin
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase

        // A chunk finished in PAD always carries the packet end.
        if (commit) begin
            meta_d[wr_slot].last  = (state_q == PAD) || S_AXIS_TLAST;
            meta_d[wr_slot].words = (state_q == PAD) ? pad_words_q : NW'(SIZE);
        end

        if (load) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            valid_d    = 1'b1;
            out_meta_d = meta_q[rd_ptr_q];
        end else if (m_chunk_ready && valid_q) begin
            valid_d = 1'b0;
        end

        level_d  = level_q + (WA+1)'(wr_en) - (load ? (WA+1)'(SIZE) : '0);
        chunks_d = chunks_q + (CA+1)'(commit) - (CA+1)'(load);
        tready_d = (state_d == FILL) && (level_d != (WA+1)'(DEPTH));
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            chunks_q    <= '0;
            pad_words_q <= '0;
            tready_q    <= 1'b0;
            valid_q     <= 1'b0;
            out_meta_q  <= '0;
            for (int i = 0; i < COUNT; i++) begin
                meta_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            chunks_q    <= chunks_d;
            pad_words_q <= pad_words_d;
            tready_q    <= tready_d;
            valid_q     <= valid_d;
            out_meta_q  <= out_meta_d;
            meta_q      <= meta_d;
        end
    end

    monolith_chunk_ram #(
        .SIZE  (SIZE),
        .COUNT (COUNT),
        .W     (W)
    ) u_ram (
        .clk     (S_AXIS_ACLK),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (load),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd)
    );

    // The RAM read register has no reset; gating on valid keeps the data outputs clear.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            m_chunk_data[i] = valid_q ? ram_rd[i] : '0;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign m_chunk_valid = valid_q;
    assign m_chunk_last  = out_meta_q.last;
    assign m_chunk_words = out_meta_q.words;
    assign fifo_level    = level_q;
    assign chunks_avail  = chunks_q;

endmodule
